// File: rtl/wb_arb_pkg.sv
// Shared encodings for the three-master Wishbone arbiter: FSM states,
// master indices and Wishbone cycle-type / burst-type constants.
package wb_arb_pkg;

   localparam int unsigned NUM_MASTERS = 3;

   typedef logic [1:0] idx_t;

   localparam idx_t CPU = 2'd0;
   localparam idx_t DSP = 2'd1;
   localparam idx_t DAQ = 2'd2;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR = 2'b00;
   localparam logic [1:0] BTE_WRAP4  = 2'b01;
   localparam logic [1:0] BTE_WRAP8  = 2'b10;
   localparam logic [1:0] BTE_WRAP16 = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_ABORT = 2'd2
   } state_t;

   function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input idx_t idx);
      logic [NUM_MASTERS-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/wb_arb_rr_grant.sv
// Combinational round-robin pick: first requester in the order that starts
// just after last_owner and wraps around.
module wb_arb_rr_grant
   import wb_arb_pkg::*;
(
   input  logic [NUM_MASTERS-1:0] req,
   input  idx_t                   last_owner,
   output logic                   valid,
   output idx_t                   next_owner
);

   idx_t cand;

   always_comb begin
      valid      = 1'b0;
      next_owner = last_owner;
      cand       = '0;
      // Walk from farthest to nearest so the nearest requester wins.
      for (int unsigned k = NUM_MASTERS; k >= 1; k--) begin
         cand = idx_t'((32'(last_owner) + k) % NUM_MASTERS);
         if (req[cand]) begin
            valid      = 1'b1;
            next_owner = cand;
         end
      end
   end

endmodule

// File: rtl/wb_master_arbiter.sv
// Three-master (cpu/dsp/daq) round-robin Wishbone arbiter onto one slave.
// Optional stalled-strobe watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_master_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 255
)(
   input  logic                        wb_clk,
   input  logic                        wb_rst_n,
   input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
   input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
   input  logic [NUM_MASTERS*(DW/8)-1:0] m_sel_i,
   input  logic [NUM_MASTERS-1:0]        m_we_i,
   input  logic [NUM_MASTERS-1:0]        m_cyc_i,
   input  logic [NUM_MASTERS-1:0]        m_stb_i,
   input  logic [NUM_MASTERS*3-1:0]      m_cti_i,
   input  logic [NUM_MASTERS*2-1:0]      m_bte_i,
   output logic [DW-1:0]                 m_dat_o,
   output logic [NUM_MASTERS-1:0]        m_ack_o,
   output logic [NUM_MASTERS-1:0]        m_err_o,
   output logic [NUM_MASTERS-1:0]        m_rty_o,
   output logic [AW-1:0]                 s_adr_o,
   output logic [DW-1:0]                 s_dat_o,
   output logic [DW/8-1:0]               s_sel_o,
   output logic                          s_we_o,
   output logic                          s_cyc_o,
   output logic                          s_stb_o,
   output logic [2:0]                    s_cti_o,
   output logic [1:0]                    s_bte_o,
   input  logic [DW-1:0]                 s_dat_i,
   input  logic                          s_ack_i,
   input  logic                          s_err_i,
   input  logic                          s_rty_i,
   output logic [NUM_MASTERS-1:0]        grant_o
);

   logic [AW-1:0]   adr [NUM_MASTERS];
   logic [DW-1:0]   dat [NUM_MASTERS];
   logic [DW/8-1:0] sel [NUM_MASTERS];
   logic [2:0]      cti [NUM_MASTERS];
   logic [1:0]      bte [NUM_MASTERS];

   for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
      assign adr[g] = m_adr_i[g*AW +: AW];
      assign dat[g] = m_dat_i[g*DW +: DW];
      assign sel[g] = m_sel_i[g*(DW/8) +: DW/8];
      assign cti[g] = m_cti_i[g*3 +: 3];
      assign bte[g] = m_bte_i[g*2 +: 2];
   end

   state_t state_q, state_d;
   idx_t   owner_q, owner_d, last_q, last_d;
   logic   rr_valid;
   idx_t   rr_next;
   logic   own_cyc, own_stb, timeout_hit;

   wb_arb_rr_grant u_rr (
      .req        (m_cyc_i),
      .last_owner (last_q),
      .valid      (rr_valid),
      .next_owner (rr_next)
   );

   assign own_cyc = m_cyc_i[owner_q];
   assign own_stb = m_stb_i[owner_q];
   assign m_dat_o = s_dat_i;
   assign grant_o = (state_q == ST_IDLE) ? '0 : idx_to_onehot(owner_q);

`ifdef WB_ARB_TIMEOUT_EN
   logic [15:0] tmo_q;
   logic        stalled;

   assign stalled     = (state_q == ST_BUSY) && own_cyc && own_stb &&
                        !(s_ack_i || s_err_i || s_rty_i);
   assign timeout_hit = stalled && ((tmo_q + 16'd1) == 16'(TIMEOUT));

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n)
         tmo_q <= '0;
      else if (stalled && !timeout_hit)
         tmo_q <= tmo_q + 16'd1;
      else
         tmo_q <= '0;
   end
`else
   logic [15:0] timeout_unused;
   assign timeout_unused = 16'(TIMEOUT);
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= CPU;
         last_q  <= DAQ;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_cti_o = '0;
      s_bte_o = '0;
      m_ack_o = '0;
      m_err_o = '0;
      m_rty_o = '0;
      case (state_q)
         ST_IDLE: begin
            if (rr_valid) begin
               owner_d = rr_next;
               last_d  = rr_next;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // Owner dropping cyc releases the bus in the same cycle.
            if (!own_cyc) begin
               state_d = ST_IDLE;
            end else begin
               s_adr_o          = adr[owner_q];
               s_dat_o          = dat[owner_q];
               s_sel_o          = sel[owner_q];
               s_we_o           = m_we_i[owner_q];
               s_cyc_o          = 1'b1;
               s_stb_o          = own_stb;
               s_cti_o          = cti[owner_q];
               s_bte_o          = bte[owner_q];
               m_ack_o[owner_q] = s_ack_i;
               m_err_o[owner_q] = s_err_i;
               m_rty_o[owner_q] = s_rty_i;
               if (timeout_hit)
                  state_d = ST_ABORT;
            end
         end
         ST_ABORT: begin
            m_err_o[owner_q] = 1'b1;
            state_d          = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter with a behavioural zero-wait slave;
// expectations follow WB_ARB_TIMEOUT_EN when it is defined.
module tb_wb_master_arbiter;
   import wb_arb_pkg::*;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 16;

   logic wb_clk = 1'b0;
   logic wb_rst_n = 1'b0;
   always #5 wb_clk = ~wb_clk;

   logic [AW-1:0] a_adr [3];
   logic [DW-1:0] a_dat [3];
   logic          a_we  [3];
   logic          a_cyc [3];
   logic          a_stb [3];
   logic [2:0]    a_cti [3];
   int unsigned   beats [3];
   logic [DW-1:0] rdata [3];

   logic [3*AW-1:0] m_adr_i;
   logic [3*DW-1:0] m_dat_i;
   logic [11:0]     m_sel_i;
   logic [2:0]      m_we_i, m_cyc_i, m_stb_i;
   logic [8:0]      m_cti_i;
   logic [5:0]      m_bte_i;
   logic [DW-1:0]   m_dat_o;
   logic [2:0]      m_ack_o, m_err_o, m_rty_o, grant_o;
   logic [AW-1:0]   s_adr_o;
   logic [DW-1:0]   s_dat_o, s_dat_i;
   logic [3:0]      s_sel_o;
   logic            s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i;
   logic [2:0]      s_cti_o;
   logic [1:0]      s_bte_o;

   always_comb begin
      m_adr_i = {a_adr[2], a_adr[1], a_adr[0]};
      m_dat_i = {a_dat[2], a_dat[1], a_dat[0]};
      m_we_i  = {a_we[2], a_we[1], a_we[0]};
      m_cyc_i = {a_cyc[2], a_cyc[1], a_cyc[0]};
      m_stb_i = {a_stb[2], a_stb[1], a_stb[0]};
      m_cti_i = {a_cti[2], a_cti[1], a_cti[0]};
   end
   assign m_sel_i = '1;
   assign m_bte_i = '0;

   wb_master_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
      .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
      .grant_o(grant_o)
   );

   // Slave: zero-wait, read data is a fixed function of the address.
   logic sl_hang, sl_rty, sl_err;
   logic [AW-1:0] wadr;
   logic [DW-1:0] wdat;
   always_comb begin
      s_ack_i = s_cyc_o & s_stb_o & ~sl_hang & ~sl_rty;
      s_rty_i = s_cyc_o & s_stb_o & sl_rty;
      s_err_i = s_cyc_o & s_stb_o & sl_err;
      s_dat_i = {16'h5A5A, s_adr_o[15:0]};
   end
   always @(posedge wb_clk) if (s_ack_i && s_we_o) begin
      wadr <= s_adr_o;
      wdat <= s_dat_o;
   end

   int unsigned ack_cnt [3];
   int unsigned bad_cnt, glog_n;
   logic [2:0]  glog [8];
   logic [2:0]  gprev;
   logic        clr;
   always @(posedge wb_clk) begin
      if (clr) begin
         for (int i = 0; i < 3; i++) ack_cnt[i] <= 0;
         bad_cnt <= 0;
         glog_n  <= 0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (m_ack_o[i[1:0]]) ack_cnt[i] <= ack_cnt[i] + 1;
            if ((m_ack_o[i[1:0]] | m_err_o[i[1:0]] | m_rty_o[i[1:0]]) && !grant_o[i[1:0]])
               bad_cnt <= bad_cnt + 1;
         end
         if (grant_o != 3'b000 && gprev == 3'b000 && glog_n < 8) begin
            glog[glog_n] <= grant_o;
            glog_n       <= glog_n + 1;
         end
      end
      gprev <= grant_o;
   end

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic clear_mon();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic set_master(input int i, input logic we, input logic [31:0] adr,
                             input logic [2:0] cti, input int unsigned n);
      a_adr[i] = adr;
      a_dat[i] = 32'hD000_0000 | adr;
      a_we[i]  = we;
      a_cti[i] = (n == 1) ? CTI_CLASSIC : cti;
      a_cyc[i] = 1'b1;
      a_stb[i] = 1'b1;
      beats[i] = n;
   endtask

   // Each master advances one beat per termination and drops cyc after its last.
   task automatic run_bus(input string tag, input int unsigned limit);
      int unsigned n = 0;
      logic term [3];
      while ((beats[0] + beats[1] + beats[2]) != 0 && n < limit) begin
         @(negedge wb_clk);
         for (int i = 0; i < 3; i++) begin
            term[i] = m_ack_o[i[1:0]] | m_err_o[i[1:0]] | m_rty_o[i[1:0]];
            if (m_ack_o[i[1:0]]) rdata[i] = m_dat_o;
         end
         tick();
         for (int i = 0; i < 3; i++) begin
            if (term[i] && beats[i] != 0) begin
               beats[i]--;
               a_adr[i] += 32'd4;
               if (beats[i] == 0) begin
                  a_cyc[i] = 1'b0;
                  a_stb[i] = 1'b0;
                  a_we[i]  = 1'b0;
                  a_cti[i] = CTI_CLASSIC;
               end else if (beats[i] == 1) begin
                  a_cti[i] = CTI_EOB;
               end
            end
         end
         n++;
      end
      check({tag, "_done"}, beats[0] + beats[1] + beats[2], 32'd0);
   endtask

   int unsigned err_at;
   logic        abort_cyc;

   initial begin
      for (int i = 0; i < 3; i++) begin
         a_adr[i] = '0; a_dat[i] = '0; a_we[i] = 1'b0; a_cyc[i] = 1'b0;
         a_stb[i] = 1'b0; a_cti[i] = CTI_CLASSIC; beats[i] = 0; rdata[i] = '0;
      end
      sl_hang = 1'b0; sl_rty = 1'b0; sl_err = 1'b0; clr = 1'b1;
      repeat (3) @(posedge wb_clk);
      #1;
      check("rst_grant", 32'(grant_o), 32'd0);
      check("rst_scyc", 32'({s_cyc_o, s_stb_o}), 32'd0);
      check("rst_term", 32'({m_ack_o, m_err_o, m_rty_o}), 32'd0);
      wb_rst_n = 1'b1;
      clr = 1'b0;

      // dsp single write
      set_master(1, 1'b1, 32'h10, CTI_CLASSIC, 1);
      a_dat[1] = 32'hA5A5_A5A5;
      #1 check("t1_pre_grant", 32'(grant_o), 32'd0);
      tick();
      check("t1_grant", 32'(grant_o), 32'b010);
      check("t1_sadr", s_adr_o, 32'h10);
      check("t1_swe_sel_bte", 32'({s_we_o, s_sel_o, s_bte_o}), 32'b1_1111_00);
      check("t1_ack", 32'(m_ack_o), 32'b010);
      tick();
      a_cyc[1] = 1'b0; a_stb[1] = 1'b0; a_we[1] = 1'b0; beats[1] = 0;
      #1 check("t1_release_scyc", 32'(s_cyc_o), 32'd0);
      tick();
      check("t1_idle", 32'(grant_o), 32'd0);
      check("t1_wadr", wadr, 32'h10);
      check("t1_wdat", wdat, 32'hA5A5_A5A5);
      check("t1_acks", {8'(ack_cnt[2]), 8'(ack_cnt[1]), 8'(ack_cnt[0])}, 32'h00_0100);

      // three simultaneous reads from reset
      wb_rst_n = 1'b0;
      #3 wb_rst_n = 1'b1;
      clear_mon();
      set_master(0, 1'b0, 32'h20, CTI_CLASSIC, 1);
      set_master(1, 1'b0, 32'h24, CTI_CLASSIC, 1);
      set_master(2, 1'b0, 32'h28, CTI_CLASSIC, 1);
      run_bus("t2", 40);
      tick();
      check("t2_ngrants", glog_n, 32'd3);
      check("t2_order", {23'd0, glog[0], glog[1], glog[2]}, 32'b001_010_100);
      check("t2_acks", {8'(ack_cnt[2]), 8'(ack_cnt[1]), 8'(ack_cnt[0])}, 32'h01_0101);
      check("t2_rd_cpu", rdata[0], 32'h5A5A_0020);
      check("t2_rd_daq", rdata[2], 32'h5A5A_0028);

      // daq burst, cpu waits
      clear_mon();
      set_master(2, 1'b0, 32'h40, CTI_INCR, 8);
      tick();
      check("t3_grant_daq", 32'(grant_o), 32'b100);
      check("t3_cti", 32'(s_cti_o), 32'(CTI_INCR));
      set_master(0, 1'b0, 32'h20, CTI_CLASSIC, 1);
      run_bus("t3", 40);
      tick();
      check("t3_order", {26'd0, glog[0], glog[1]}, 32'b100_001);
      check("t3_acks", {8'(ack_cnt[2]), 8'(ack_cnt[1]), 8'(ack_cnt[0])}, 32'h08_0001);
      check("t3_last_beat", rdata[2], 32'h5A5A_005C);
      check("t3_no_stray", bad_cnt, 32'd0);

      // retry to cpu, no preemption, ack+err forwarded together
      clear_mon();
      sl_rty = 1'b1;
      a_adr[0] = 32'h30; a_cyc[0] = 1'b1; a_stb[0] = 1'b1;
      tick();
      check("t4_grant", 32'(grant_o), 32'b001);
      check("t4_rty", 32'({m_rty_o, m_ack_o}), 32'b001_000);
      set_master(1, 1'b0, 32'h34, CTI_CLASSIC, 1);
      repeat (3) tick();
      check("t4_held", 32'(grant_o), 32'b001);
      sl_rty = 1'b0; sl_err = 1'b1;
      #1 check("t4_ack_err", 32'({m_ack_o, m_err_o}), 32'b001_001);
      sl_err = 1'b0; a_cyc[0] = 1'b0; a_stb[0] = 1'b0;
      tick();
      check("t4_release", 32'(grant_o), 32'd0);
      tick();
      check("t4_next_dsp", 32'(grant_o), 32'b010);
      run_bus("t4", 10);
      check("t4_acks", {8'(ack_cnt[1]), 8'(ack_cnt[0])}, 32'h0100);
      check("t4_no_stray", bad_cnt, 32'd0);

      // hung slave
      clear_mon();
      sl_hang = 1'b1;
      err_at = 0;
      abort_cyc = 1'b1;
      a_adr[2] = 32'h50; a_cyc[2] = 1'b1; a_stb[2] = 1'b1;
      tick();
      check("t5_grant", 32'(grant_o), 32'b100);
      for (int unsigned k = 1; k <= 40 && err_at == 0; k++) begin
         if (m_err_o[2]) begin
            err_at = k;
            abort_cyc = s_cyc_o;
         end
         tick();
      end
`ifdef WB_ARB_TIMEOUT_EN
      check("t5_err_cycle", err_at, TMO + 1);
      check("t5_abort_scyc", 32'(abort_cyc), 32'd0);
      check("t5_released", 32'(grant_o), 32'd0);
`else
      check("t5_no_err", err_at, 32'd0);
      check("t5_held", 32'(grant_o), 32'b100);
`endif
      a_cyc[2] = 1'b0; a_stb[2] = 1'b0; sl_hang = 1'b0;
      tick();
      tick();

      // reset during dsp burst beat 3
      clear_mon();
      set_master(1, 1'b0, 32'h60, CTI_INCR, 8);
      repeat (3) tick();
      check("t6_beat3_ack", 32'(m_ack_o), 32'b010);
      set_master(0, 1'b0, 32'h70, CTI_CLASSIC, 1);
      wb_rst_n = 1'b0;
      #1 check("t6_rst_drop", 32'({s_cyc_o, s_stb_o, grant_o, m_ack_o}), 32'd0);
      tick();
      wb_rst_n = 1'b1;
      check("t6_dsp_acks", ack_cnt[1], 32'd2);
      tick();
      check("t6_first_cpu", 32'(grant_o), 32'b001);
      for (int i = 0; i < 3; i++) begin
         a_cyc[i] = 1'b0; a_stb[i] = 1'b0; beats[i] = 0;
      end
      tick();
      tick();
      check("t6_no_stray", bad_cnt, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
